// File: rtl/enc8to3_seq.sv
// enc8to3_seq: sequential 8-to-3 priority encoder.
// Captures a request vector, then emits one index per accepted valid/ready
// transfer in priority order, clearing each served bit. A one-cycle done
// pulse marks the end of a batch, including a load of an empty vector.
// Optional build macro ENC_PEND_CNT_EN adds pend_cnt, the registered
// population count of the pending requests.
module enc8to3_seq #(
    parameter bit PRIO_HIGH = 1'b1  // 1: bit 7 served first, 0: bit 0 served first
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] d,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] idx,
    output logic       done
`ifdef ENC_PEND_CNT_EN
    ,
    output logic [3:0] pend_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [2:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic       busy_q, valid_q;
    logic       xfer;

    // Highest-priority set bit; later loop hits overwrite earlier ones.
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign xfer = valid_q & out_ready;

    // Next-state: capture in IDLE, clear the served bit on each transfer.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (|d) begin
                        pend_d  = d;
                        state_d = SERVE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (xfer) begin
                    pend_d = pend_q & ~(8'b1 << idx_q);
                    if (pend_d == 8'h00) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // idx is re-encoded only when something remains, so it holds otherwise.
        idx_d = (|pend_d) ? prio_enc(pend_d) : idx_q;
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= 8'h00;
            idx_q   <= 3'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            busy_q  <= (state_d == SERVE);
            valid_q <= (state_d == SERVE);
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign idx       = idx_q;
    assign done      = done_q;

`ifdef ENC_PEND_CNT_EN
    logic [3:0] cnt_q, cnt_d;

    // Pending count tracks pend: loaded with popcount, minus one per transfer.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (load) cnt_d = 4'($countones(d));
        end else if (xfer) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= 4'd0;
        else        cnt_q <= cnt_d;
    end

    assign pend_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_enc8to3_seq.sv
// Bench for enc8to3_seq: two instances (high- and low-priority ordering)
// share stimulus; a negedge monitor pops expected indices per transfer.
module tb_enc8to3_seq;

    logic       clk = 1'b0;
    logic       rst_n, load, out_ready;
    logic [7:0] d;
    logic       busy_h, out_valid_h, done_h;
    logic       busy_l, out_valid_l, done_l;
    logic [2:0] idx_h, idx_l;
`ifdef ENC_PEND_CNT_EN
    logic [3:0] pend_cnt_h, pend_cnt_l;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int qh[$];
    int ql[$];

    always #5 clk = ~clk;

    enc8to3_seq #(.PRIO_HIGH(1'b1)) u_hi (
        .clk(clk), .rst_n(rst_n), .load(load), .d(d), .busy(busy_h),
        .out_valid(out_valid_h), .out_ready(out_ready), .idx(idx_h), .done(done_h)
`ifdef ENC_PEND_CNT_EN
        , .pend_cnt(pend_cnt_h)
`endif
    );

    enc8to3_seq #(.PRIO_HIGH(1'b0)) u_lo (
        .clk(clk), .rst_n(rst_n), .load(load), .d(d), .busy(busy_l),
        .out_valid(out_valid_l), .out_ready(out_ready), .idx(idx_l), .done(done_l)
`ifdef ENC_PEND_CNT_EN
        , .pend_cnt(pend_cnt_l)
`endif
    );

    // Expected service order for both priority settings.
    task automatic push_exp(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) qh.push_back(i);
        for (int i = 0; i < 8; i++) if (v[i]) ql.push_back(i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: a transfer happens at the next edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_ready === 1'b1) begin
            if (out_valid_h === 1'b1) begin
                n_total++;
                if (qh.size() == 0) $display("FAIL sb_hi: unexpected idx=%0d", idx_h);
                else begin
                    int e;
                    e = qh.pop_front();
                    if (idx_h !== 3'(e)) $display("FAIL sb_hi: idx=%0d expected %0d", idx_h, e);
                    else n_pass++;
                end
            end
            if (out_valid_l === 1'b1) begin
                n_total++;
                if (ql.size() == 0) $display("FAIL sb_lo: unexpected idx=%0d", idx_l);
                else begin
                    int e;
                    e = ql.pop_front();
                    if (idx_l !== 3'(e)) $display("FAIL sb_lo: idx=%0d expected %0d", idx_l, e);
                    else n_pass++;
                end
            end
        end
    end

    // Waits for done; checks cycle count, valid count, idle state, one-cycle pulse.
    task automatic wait_done(input string nm, input int exp_n);
        int n  = 0;
        int nv = 0;
        bit got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (done_h === 1'b1) got = 1;
            else begin
                n++;
                if (out_valid_h === 1'b1) nv++;
            end
        end
        n_total++;
        if (got && n == exp_n && nv == exp_n) n_pass++;
        else $display("FAIL %s_timing: done=%0b after %0d cycles (%0d valid), expected %0d", nm, got, n, nv, exp_n);
        n_total++;
        if (out_valid_h === 1'b0 && busy_h === 1'b0 && out_valid_l === 1'b0 && busy_l === 1'b0 &&
            done_l === 1'b1 && qh.size() == 0 && ql.size() == 0) n_pass++;
        else $display("FAIL %s_idle: vh=%b bh=%b vl=%b bl=%b dl=%b qh=%0d ql=%0d, expected 0 0 0 0 1 0 0",
                      nm, out_valid_h, busy_h, out_valid_l, busy_l, done_l, qh.size(), ql.size());
        @(negedge clk);
        n_total++;
        if (done_h === 1'b0 && done_l === 1'b0) n_pass++;
        else $display("FAIL %s_pulse: done_h=%b done_l=%b, expected 0 0", nm, done_h, done_l);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; d = 8'h00; out_ready = 1'b0;
        step(); step();
        @(negedge clk);
        n_total++;
        if (busy_h === 1'b0 && out_valid_h === 1'b0 && idx_h === 3'd0 && done_h === 1'b0 &&
            busy_l === 1'b0 && out_valid_l === 1'b0 && idx_l === 3'd0 && done_l === 1'b0) n_pass++;
        else $display("FAIL reset: busy=%b valid=%b idx=%0d done=%b, expected 0 0 0 0", busy_h, out_valid_h, idx_h, done_h);
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_prio();
        out_ready = 1'b1;
        step(); load = 1'b1; d = 8'hA5; push_exp(8'hA5);
        step(); load = 1'b0;
        wait_done("prio_a5", 4);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        step(); load = 1'b1; d = 8'h81; push_exp(8'h81);
        step(); load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_total++;
            if (out_valid_h === 1'b1 && idx_h === 3'd7 && out_valid_l === 1'b1 && idx_l === 3'd0) n_pass++;
            else $display("FAIL stall%0d: valid=%b idx_h=%0d idx_l=%0d, expected 1 7 0", k, out_valid_h, idx_h, idx_l);
        end
        step(); out_ready = 1'b1;
        wait_done("bp_81", 2);
    endtask

    task automatic test_ignored_load();
        out_ready = 1'b1;
        step(); load = 1'b1; d = 8'h0F; push_exp(8'h0F);
        step(); load = 1'b0;
        step(); load = 1'b1; d = 8'hF0;
        step(); load = 1'b0; d = 8'h00;
        wait_done("ign_0f", 2);
        step(); load = 1'b1; d = 8'h00;
        step(); load = 1'b0;
        wait_done("zero_load", 0);
    endtask

    task automatic test_reset_mid_serve();
        out_ready = 1'b1;
        step(); load = 1'b1; d = 8'hA5; push_exp(8'hA5);
        step(); load = 1'b0;
        step();
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        n_total++;
        if (qh.size() == 2 && ql.size() == 2) n_pass++;
        else $display("FAIL mid_xfers: remaining qh=%0d ql=%0d, expected 2 2", qh.size(), ql.size());
        qh.delete(); ql.delete();
        @(negedge clk);
        n_total++;
        if (busy_h === 1'b0 && out_valid_h === 1'b0 && idx_h === 3'd0 && done_h === 1'b0 &&
            busy_l === 1'b0 && out_valid_l === 1'b0 && idx_l === 3'd0 && done_l === 1'b0) n_pass++;
        else $display("FAIL mid_reset: busy=%b valid=%b idx=%0d done=%b, expected 0 0 0 0", busy_h, out_valid_h, idx_h, done_h);
`ifdef ENC_PEND_CNT_EN
        n_total++;
        if (pend_cnt_h === 4'd0 && pend_cnt_l === 4'd0) n_pass++;
        else $display("FAIL mid_reset_cnt: pend_cnt=%0d, expected 0", pend_cnt_h);
`endif
        step(); load = 1'b1; d = 8'h06; push_exp(8'h06);
        step(); load = 1'b0;
        wait_done("after_reset", 2);
    endtask

`ifdef ENC_PEND_CNT_EN
    task automatic test_pend_cnt();
        out_ready = 1'b1;
        step(); load = 1'b1; d = 8'hFF; push_exp(8'hFF);
        step(); load = 1'b0;
        for (int k = 8; k >= 1; k--) begin
            @(negedge clk);
            n_total++;
            if (pend_cnt_h === 4'(k) && pend_cnt_l === 4'(k)) n_pass++;
            else $display("FAIL cnt_%0d: pend_cnt=%0d/%0d, expected %0d", k, pend_cnt_h, pend_cnt_l, k);
        end
        @(negedge clk);
        n_total++;
        if (done_h === 1'b1 && pend_cnt_h === 4'd0 && out_valid_h === 1'b0 && qh.size() == 0 && ql.size() == 0) n_pass++;
        else $display("FAIL cnt_done: done=%b cnt=%0d valid=%b q=%0d, expected 1 0 0 0", done_h, pend_cnt_h, out_valid_h, qh.size());
        load = 1'b1; d = 8'h10; push_exp(8'h10);
        step(); load = 1'b0;
        @(negedge clk);
        n_total++;
        if (pend_cnt_h === 4'd1 && idx_h === 3'd4 && idx_l === 3'd4 && out_valid_h === 1'b1 && done_h === 1'b0) n_pass++;
        else $display("FAIL cnt_reload: cnt=%0d idx=%0d valid=%b done=%b, expected 1 4 1 0", pend_cnt_h, idx_h, out_valid_h, done_h);
        wait_done("cnt_10", 0);
    endtask
`endif

    initial begin
        fork
            begin
                #200000;
                $display("FAIL watchdog: simulation did not finish, expected completion");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_prio();
        test_backpressure();
        test_ignored_load();
        test_reset_mid_serve();
`ifdef ENC_PEND_CNT_EN
        test_pend_cnt();
`endif
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/enc8to3_seq.md
Name: enc8to3_seq

Overview:
- Sequential 8-to-3 priority encoder: the inverse of the team's 3-to-8 decoders.
- Captures an 8-bit request vector and emits one 3-bit index per served request.
- Output uses a valid/ready handshake. Each served bit is cleared, and the block returns to idle when no requests remain.
- Feeds downstream decoder/dispatch logic. A served index drives the 3-to-8 decoder inputs (a=idx[2], b=idx[1], c=idx[0]) to regenerate the one-hot line.

Parameters:
- PRIO_HIGH, 1, 1 = d[7] has highest priority; 0 = d[0] has highest priority.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- load  input  1  capture request vector d; honoured only when busy=0.
- d  input  8  request vector; bit i requests index i.
- busy  output  1  1 while requests are pending (state SERVE).
- out_valid  output  1  idx holds a valid pending index.
- out_ready  input  1  consumer accepts idx when out_valid=1.
- idx  output  3  encoded index of the highest-priority pending bit.
- done  output  1  single-cycle pulse after the last index of a batch is accepted.

Behaviour:
- Reset: on a clock edge with rst_n=0, all state clears regardless of current state. Result: state=IDLE, pend=8'h00, busy=0, out_valid=0, idx=3'd0, done=0.
- State register: IDLE or SERVE. pend[7:0] holds the remaining requests.
- IDLE, load=1, d!=0:
  - pend <= d, next state SERVE.
  - busy=1 and out_valid=1 from the following cycle (1-cycle latency).
- IDLE, load=1, d==0: stay in IDLE, done=1 for exactly the next cycle. No output is produced.
- IDLE, load=0: hold. done=0 except as specified elsewhere.
- SERVE:
  - out_valid=1.
  - idx = position of the highest-priority set bit of pend (per PRIO_HIGH), derived from registered pend only.
  - load and d are ignored.
- Handshake: a transfer occurs on an edge with out_valid=1 and out_ready=1.
  - That bit of pend clears.
  - idx for the next remaining bit appears the next cycle, giving back-to-back transfers at 1 per cycle.
- Stall: while out_ready=0, idx and pend hold stable. No bit is lost or reordered.
- Last transfer (pend has exactly one bit set and a handshake occurs):
  - Next cycle: IDLE, busy=0, out_valid=0, done=1 for one cycle.
  - A load is accepted in that same done cycle. There is no dead cycle beyond done.
- out_ready while out_valid=0 has no effect.
- idx when out_valid=0 holds its last value (don't-care for consumers; reset value is 0).
- Single-bit vector: one transfer, then done.
- d=8'hFF: 8 transfers in priority order.

Optional Feature:
- Macro: ENC_PEND_CNT_EN.
- Defined: adds output pend_cnt [3:0] = population count of pend, registered alongside pend.
  - Reset value 0.
  - Equals popcount(d) the cycle after a load.
  - Decrements by 1 per transfer.
  - 0 in IDLE.
- Not defined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset mid-SERVE: load d=8'hA5, 2 transfers, then rst_n=0 for one edge -> next cycle busy=0, out_valid=0, idx=0, done=0. A subsequent load is served normally.
- PRIO_HIGH=1, load d=8'hA5, out_ready held 1 -> idx sequence 7,5,2,0 on 4 consecutive cycles, then done=1 for one cycle.
- PRIO_HIGH=0, load d=8'hA5 -> idx sequence 0,2,5,7.
- Back-pressure: load d=8'h81, out_ready=0 for 5 cycles -> idx=7 held stable, out_valid=1. Release -> 7 then 0, then done.
- Ignored load: during SERVE of d=8'h0F, pulse load with d=8'hF0 -> only indices 3,2,1,0 are produced. load d=8'h00 in IDLE -> done=1 for one cycle, out_valid stays 0.
- ENC_PEND_CNT_EN: load d=8'hFF -> pend_cnt 8,7,...,1 across transfers, then 0. Load in the done cycle with d=8'h10 -> pend_cnt=1 the next cycle, idx=4.
